// File: rtl/long_shift_pkg.sv
// Shared encodings, state type and the per-step shift helper for the
// long-result shift sequencer.
package long_shift_pkg;

    localparam int DEFAULT_STEP = 8;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsmState_t;

    // Shift by a constant k; the 128-bit form lets the fill (zero, sign or the
    // wrapped operand itself) arrive through one right shift.
    function automatic logic [63:0] shiftStep(input logic [63:0] w,
                                              input logic [1:0]  op,
                                              input int          k);
        logic [127:0] wide;
        case (op)
            OP_SLL:  wide = {64'd0, w << k};
            OP_SRL:  wide = {64'd0, w} >> k;
            OP_SRA:  wide = {{64{w[63]}}, w} >> k;
            default: wide = {w, w} >> k;
        endcase
        return wide[63:0];
    endfunction

endpackage

// File: rtl/long_shift_step.sv
// Combinational step shifter: moves the 64-bit working value by s positions,
// where s never exceeds STEP, so only STEP+1 fixed shifts are built.
module long_shift_step
    import long_shift_pkg::*;
#(
    parameter int STEP = DEFAULT_STEP
) (
    input  logic [63:0] wIn,
    input  logic [1:0]  op,
    input  logic [5:0]  s,
    output logic [63:0] wOut
);

    always_comb begin
        wOut = wIn;
        for (int k = 1; k <= STEP; k++) begin
            if (s == 6'(k)) begin
                wOut = shiftStep(wIn, op, k);
            end
        end
    end

endmodule

// File: rtl/long_shift_seq.sv
// Multi-cycle 64-bit shift sequencer: accepts a {hi, lo} shift request,
// walks it STEP bits per cycle and returns the result over valid/ready.
module long_shift_seq
    import long_shift_pkg::*;
#(
    parameter int STEP = DEFAULT_STEP
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  op,
    input  logic [31:0] src_high,
    input  logic [31:0] src_low,
    input  logic [5:0]  amount,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] res_high,
    output logic [31:0] res_low,
    output logic        busy,
    output logic [1:0]  dbgState
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and flush overrides both sides.

    localparam logic [5:0] STEP6 = 6'(STEP);

    fsmState_t   state;
    logic [63:0] wReg;
    logic [63:0] wNext;
    logic [1:0]  opReg;
    logic [5:0]  remaining;
    logic [5:0]  stepAmt;

    always_comb begin
        stepAmt = (remaining > STEP6) ? STEP6 : remaining;
    end

    long_shift_step #(.STEP(STEP)) uStep (
        .wIn  (wReg),
        .op   (opReg),
        .s    (stepAmt),
        .wOut (wNext)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wReg      <= 64'd0;
            opReg     <= OP_SLL;
            remaining <= 6'd0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        opReg     <= op;
                        wReg      <= {src_high, src_low};
                        remaining <= amount;
                        state     <= (amount == 6'd0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    wReg      <= wNext;
                    remaining <= remaining - stepAmt;
                    if (remaining <= STEP6) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything but req_ready is a register or a state decode.
    assign req_ready = (state == IDLE) && !flush;
    assign rsp_valid = (state == DONE);
    assign busy      = (state == SHIFT) || (state == DONE);
    assign res_high  = wReg[63:32];
    assign res_low   = wReg[31:0];
    assign dbgState  = state;

endmodule

// File: tb/tb_long_shift_seq.sv
// Bench for long_shift_seq: three instances (STEP 1, 8, 32) share stimulus and
// are compared against a plain 64-bit shift model, vector table and corner cases.
module tb_long_shift_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        reqValid = 1'b0;
    logic        rspReady = 1'b0;
    logic [1:0]  opIn = 2'b00;
    logic [31:0] srcHigh = 32'd0;
    logic [31:0] srcLow = 32'd0;
    logic [5:0]  amountIn = 6'd0;

    logic        reqReady[3];
    logic        rspValid[3];
    logic [31:0] resHigh[3];
    logic [31:0] resLow[3];
    logic        busyOut[3];
    logic [1:0]  dbgState[3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : gDut
        long_shift_seq #(.STEP(g == 0 ? 1 : (g == 1 ? 8 : 32))) uDut (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .req_valid (reqValid),
            .req_ready (reqReady[g]),
            .op        (opIn),
            .src_high  (srcHigh),
            .src_low   (srcLow),
            .amount    (amountIn),
            .rsp_valid (rspValid[g]),
            .rsp_ready (rspReady),
            .res_high  (resHigh[g]),
            .res_low   (resLow[g]),
            .busy      (busyOut[g]),
            .dbgState  (dbgState[g])
        );
    end

    function automatic int stepOf(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 8 : 32);
    endfunction

    // Reference: one plain 64-bit shift by the whole amount.
    function automatic logic [63:0] refShift(input logic [1:0] o, input logic [63:0] x, input int a);
        case (o)
            2'b00:   return x << a;
            2'b01:   return x >> a;
            2'b10:   return 64'($signed(x) >>> a);
            default: return (a == 0) ? x : ((x >> a) | (x << (64 - a)));
        endcase
    endfunction

    function automatic int refLatency(input int a, input int s);
        return 1 + (a + s - 1) / s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chkResetState(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_rsp_valid%0d", tag, d), 64'(rspValid[d]), 64'd0);
            chk($sformatf("%s_busy%0d", tag, d), 64'(busyOut[d]), 64'd0);
            chk($sformatf("%s_res%0d", tag, d), {resHigh[d], resLow[d]}, 64'd0);
            chk($sformatf("%s_req_ready%0d", tag, d), 64'(reqReady[d]), 64'd1);
            chk($sformatf("%s_state%0d", tag, d), 64'(dbgState[d]), 64'd0);
        end
    endtask

    // One request to all three instances, consumed as soon as each is valid.
    task automatic runOp(input logic [1:0] o, input logic [63:0] x, input int a,
                         input logic [63:0] expV, input int expLat8, input string tag);
        bit done[3];
        int lat;
        bit allDone;
        for (int d = 0; d < 3; d++) done[d] = 1'b0;
        @(negedge clock);
        chk($sformatf("%s_ready", tag), 64'(reqReady[1]), 64'd1);
        opIn = o; srcHigh = x[63:32]; srcLow = x[31:0]; amountIn = 6'(a);
        reqValid = 1'b1; rspReady = 1'b1;
        @(negedge clock);
        reqValid = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            allDone = 1'b1;
            for (int d = 0; d < 3; d++) begin
                if (!done[d]) begin
                    chk($sformatf("%s_busy%0d", tag, d), 64'(busyOut[d]), 64'd1);
                    if (rspValid[d]) begin
                        done[d] = 1'b1;
                        lat = (d == 1) ? expLat8 : refLatency(a, stepOf(d));
                        chk($sformatf("%s_res%0d op%0d amt%0d", tag, d, o, a), {resHigh[d], resLow[d]}, expV);
                        chk($sformatf("%s_lat%0d op%0d amt%0d", tag, d, o, a), 64'(cyc), 64'(lat));
                    end else begin
                        allDone = 1'b0;
                    end
                end
            end
            if (allDone) break;
            @(negedge clock);
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_timeout%0d", tag, d), 64'(done[d]), 64'd1);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [63:0] src;
        int          amt;
        logic [63:0] exp;
        int          lat8;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] x;
        bit seen;

        vecs[0] = '{2'b00, 64'h00000000_00000001, 40, 64'h00000100_00000000, 6};
        vecs[1] = '{2'b10, 64'h80000000_00000000, 63, 64'hFFFFFFFF_FFFFFFFF, 9};
        vecs[2] = '{2'b01, 64'h12345678_9ABCDEF0, 0,  64'h12345678_9ABCDEF0, 1};
        vecs[3] = '{2'b11, 64'h00000000_00000001, 1,  64'h80000000_00000000, 2};
        vecs[4] = '{2'b01, 64'h80000000_00000000, 63, 64'h00000000_00000001, 9};
        vecs[5] = '{2'b11, 64'h00000000_000000FF, 8,  64'hFF000000_00000000, 2};
        vecs[6] = '{2'b10, 64'h40000000_00000000, 62, 64'h00000000_00000001, 9};
        vecs[7] = '{2'b00, 64'hFFFFFFFF_FFFFFFFF, 9,  64'hFFFFFFFF_FFFFFE00, 3};

        // Clock/reset
        #12;
        chkResetState("por");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chkResetState("after_reset");

        // Vector table
        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].op, vecs[i].src, vecs[i].amt, vecs[i].exp, vecs[i].lat8, $sformatf("vec%0d", i));
        end

        // Held response, then back-to-back request
        @(negedge clock);
        opIn = 2'b11; srcHigh = 32'd0; srcLow = 32'd1; amountIn = 6'd1;
        reqValid = 1'b1; rspReady = 1'b0;
        @(negedge clock);
        reqValid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (rspValid[1]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("hold_seen", 64'(seen), 64'd1);
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("hold%0d_valid%0d", k, d), 64'(rspValid[d]), 64'd1);
                chk($sformatf("hold%0d_res%0d", k, d), {resHigh[d], resLow[d]}, 64'h80000000_00000000);
                chk($sformatf("hold%0d_ready%0d", k, d), 64'(reqReady[d]), 64'd0);
            end
            @(negedge clock);
        end
        rspReady = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("release_ready%0d", d), 64'(reqReady[d]), 64'd1);
            chk($sformatf("release_valid%0d", d), 64'(rspValid[d]), 64'd0);
        end
        opIn = 2'b01; srcHigh = 32'hDEADBEEF; srcLow = 32'hCAFEF00D; amountIn = 6'd0;
        reqValid = 1'b1;
        @(negedge clock);
        reqValid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("b2b_valid%0d", d), 64'(rspValid[d]), 64'd1);
            chk($sformatf("b2b_res%0d", d), {resHigh[d], resLow[d]}, 64'hDEADBEEF_CAFEF00D);
        end
        @(negedge clock);

        // Flush two cycles after accept drops the operation
        opIn = 2'b00; srcHigh = 32'd0; srcLow = 32'h000000A5; amountIn = 6'd32;
        reqValid = 1'b1; rspReady = 1'b0;
        @(negedge clock);
        reqValid = 1'b0;
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        rspReady = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("flush_busy%0d", d), 64'(busyOut[d]), 64'd0);
            chk($sformatf("flush_state%0d", d), 64'(dbgState[d]), 64'd0);
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            for (int d = 0; d < 3; d++) if (rspValid[d]) seen = 1'b1;
            @(negedge clock);
        end
        chk("flush_no_rsp", 64'(seen), 64'd0);

        // Flush with a request in IDLE: flush wins
        flush = 1'b1; reqValid = 1'b1; amountIn = 6'd5;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("flushreq_ready%0d", d), 64'(reqReady[d]), 64'd0);
        @(negedge clock);
        flush = 1'b0; reqValid = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("flushreq_busy%0d", d), 64'(busyOut[d]), 64'd0);
            chk($sformatf("flushreq_ready_after%0d", d), 64'(reqReady[d]), 64'd1);
        end

        // Asynchronous reset mid-operation
        @(negedge clock);
        opIn = 2'b00; srcHigh = 32'hFFFFFFFF; srcLow = 32'hFFFFFFFF; amountIn = 6'd32;
        reqValid = 1'b1;
        @(negedge clock);
        reqValid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chkResetState("async_reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chkResetState("after_async_reset");

        // Randomised sweep of every op and amount
        for (int o = 0; o < 4; o++) begin
            for (int a = 0; a < 64; a++) begin
                x = {$urandom, $urandom};
                runOp(2'(o), x, a, refShift(2'(o), x, a), refLatency(a, 8), "sweep");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/long_shift_seq.md
# long_shift_seq

Multi-cycle 64-bit shift sequencer for the ALU's long-result path. It accepts a shift request on the {hi, lo} register pair and walks the operand through a bounded-width shift step once per cycle. It returns the 64-bit result as res_high/res_low through a valid/ready handshake. It sits between the execute-stage control and the hi/lo result registers, replacing single-cycle wide shifting with a small, reusable step shifter.

## Interface
- STEP, 8: maximum shift per cycle; legal values 1, 2, 4, 8, 16, 32.
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; drops any operation in flight.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a clock edge where req_valid & req_ready.
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (64-bit rotate right).
- src_high  in  32  operand bits 63:32.
- src_low  in  32  operand bits 31:0.
- amount  in  6  shift distance, 0..63.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer takes result on an edge where rsp_valid & rsp_ready.
- res_high  out  32  result bits 63:32.
- res_low  out  32  result bits 31:0.
- busy  out  1  high in SHIFT or DONE.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - req_ready = ~flush.
  - On accept, latch op, latch {src_high, src_low} into a 64-bit working register W, and latch remaining = amount.
  - Next state is DONE if amount == 0, else SHIFT.
- SHIFT:
  - Each edge: s = min(remaining, STEP); W = step(W, op, s); remaining -= s.
  - When remaining ≤ STEP, the step is taken and the next state is DONE.
- DONE:
  - rsp_valid = 1.
  - W holds stable until rsp_ready is sampled high, then the FSM returns to IDLE.
- Arithmetic:
  - SLL: zero fill at bit 0.
  - SRL: zero fill at bit 63.
  - SRA: fill with the current W[63]; repeated steps preserve the original sign.
  - ROR: bits leaving bit 0 enter at bit 63.
  - The result equals a single 64-bit shift by amount, independent of STEP.
- res_high/res_low continuously drive W[63:32]/W[31:0]. They are meaningful only while rsp_valid is high.
- flush:
  - In any state, flush forces IDLE on the next edge.
  - A response that was pending is dropped; no rsp_valid is produced.
  - In IDLE, flush and req_valid together: flush wins, and the request is not accepted.
- Asynchronous reset mid-operation: immediately IDLE, W = 0, remaining = 0, and the operation is lost.
- A request is never accepted while busy; operations do not overlap.

## Timing
- Reset values: rsp_valid 0, busy 0, res_high 0, res_low 0, req_ready 1 (flush low).
- Latency from accept edge to first cycle of rsp_valid is 1 + ceil(amount / STEP) cycles; amount 0 gives 1 cycle.
- With STEP 8, worst case is amount 63: 9 cycles.
- A response consumed at edge E puts the FSM in IDLE after E, so req_ready is high in the following cycle.
- Minimum spacing between accepts is latency + 1 cycles.
- rsp_valid, res_high, res_low and busy are glitch-free: they are direct register outputs or decodes of the state register only.
- req_ready also depends combinationally on flush.

## Structure
- Package long_shift_pkg holds:
  - op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROR;
  - the state enum: IDLE, SHIFT, DONE;
  - the default STEP.
- Sub-module long_shift_step: purely combinational, 64-bit W, op, s in 0..STEP, producing the next W.
- The top level holds the FSM, W, remaining, and handshake logic.

## Test plan
- SLL, src {0x00000000, 0x00000001}, amount 40, STEP 8 -> res {0x00000100, 0x00000000}; rsp_valid 6 cycles after accept.
- SRA, src {0x80000000, 0x00000000}, amount 63 -> res {0xFFFFFFFF, 0xFFFFFFFF}; latency 9; busy high throughout.
- SRL, src {0x12345678, 0x9ABCDEF0}, amount 0 -> same value returned; latency 1.
- ROR, src {0x00000000, 0x00000001}, amount 1 -> res {0x80000000, 0x00000000}; hold rsp_ready low 3 cycles -> outputs stable, req_ready 0; release -> req_ready 1 the next cycle; back-to-back second request accepted.
- SLL, amount 32: assert flush 2 cycles after accept -> IDLE next edge, no rsp_valid. Repeat with reset pulsed low mid-SHIFT -> all outputs at reset values immediately.
- Sweep amount 0..63 for all ops, STEP in {1, 8, 32}, random operands -> match a 64-bit reference shift; latency equals 1 + ceil(amount / STEP).
